// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of the data-memory interface: grants one requester per
// access, holds its fields through ACC/RSP and returns load data on the granted port.
module riscv_dmem_arbiter #(
    parameter  int unsigned ARB_RR = 1,
    localparam int unsigned XLEN   = 32,
    localparam int unsigned BSW    = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_arb_req0,
    input  logic [XLEN-1:0] i_arb_addr0,
    input  logic            i_arb_wen0,
    input  logic [BSW-1:0]  i_arb_byte_sel0,
    input  logic [XLEN-1:0] i_arb_wr_data0,
    input  logic [2:0]      i_arb_func30,
    input  logic            i_arb_req1,
    input  logic [XLEN-1:0] i_arb_addr1,
    input  logic            i_arb_wen1,
    input  logic [BSW-1:0]  i_arb_byte_sel1,
    input  logic [XLEN-1:0] i_arb_wr_data1,
    input  logic [2:0]      i_arb_func31,
    output logic            o_arb_gnt0,
    output logic            o_arb_rvalid0,
    output logic [XLEN-1:0] o_arb_rd_data0,
    output logic            o_arb_gnt1,
    output logic            o_arb_rvalid1,
    output logic [XLEN-1:0] o_arb_rd_data1,
    output logic [XLEN-1:0] o_arb_addr,
    output logic            o_arb_wen,
    output logic [BSW-1:0]  o_arb_byte_sel,
    output logic [XLEN-1:0] o_arb_wr_data,
    output logic [2:0]      o_arb_func3,
    input  logic [XLEN-1:0] i_arb_rd_data,
    output logic            o_arb_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_arb_en;
    logic   w_winner;
    logic   r_cur_port;
    logic   r_last_port;
    logic   r_wen;

    logic [XLEN-1:0] w_sel_addr;
    logic            w_sel_wen;
    logic [BSW-1:0]  w_sel_byte_sel;
    logic [XLEN-1:0] w_sel_wr_data;
    logic [2:0]      w_sel_func3;

    assign w_sel_addr     = w_winner ? i_arb_addr1     : i_arb_addr0;
    assign w_sel_wen      = w_winner ? i_arb_wen1      : i_arb_wen0;
    assign w_sel_byte_sel = w_winner ? i_arb_byte_sel1 : i_arb_byte_sel0;
    assign w_sel_wr_data  = w_winner ? i_arb_wr_data1  : i_arb_wr_data0;
    assign w_sel_func3    = w_winner ? i_arb_func31    : i_arb_func30;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus arbitration; a contested grant goes away from last_port in RR mode.
    always_comb begin
        w_next   = r_state;
        w_arb_en = 1'b0;
        if (i_arb_req0 && i_arb_req1) w_winner = (ARB_RR != 0) ? ~r_last_port : 1'b0;
        else                          w_winner = ~i_arb_req0;
        case (r_state)
            IDLE: begin
                if (i_arb_req0 || i_arb_req1) begin
                    w_next   = ACC;
                    w_arb_en = 1'b1;
                end
            end
            ACC: w_next = RSP;
            RSP: begin
                if (i_arb_req0 || i_arb_req1) begin
                    w_next   = ACC;
                    w_arb_en = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_port     <= 1'b0;
            r_last_port    <= 1'b1;
            r_wen          <= 1'b0;
            o_arb_gnt0     <= 1'b0;
            o_arb_gnt1     <= 1'b0;
            o_arb_rvalid0  <= 1'b0;
            o_arb_rvalid1  <= 1'b0;
            o_arb_rd_data0 <= '0;
            o_arb_rd_data1 <= '0;
            o_arb_addr     <= '0;
            o_arb_wen      <= 1'b0;
            o_arb_byte_sel <= '0;
            o_arb_wr_data  <= '0;
            o_arb_func3    <= '0;
            o_arb_busy     <= 1'b0;
        end else begin
            o_arb_gnt0    <= w_arb_en && !w_winner;
            o_arb_gnt1    <= w_arb_en && w_winner;
            o_arb_wen     <= w_arb_en && w_sel_wen;
            o_arb_busy    <= (w_next != IDLE);
            o_arb_rvalid0 <= (r_state == RSP) && !r_cur_port;
            o_arb_rvalid1 <= (r_state == RSP) && r_cur_port;
            // Load data is only captured for loads; stores leave the port's result untouched.
            if ((r_state == RSP) && !r_wen) begin
                if (r_cur_port) o_arb_rd_data1 <= i_arb_rd_data;
                else            o_arb_rd_data0 <= i_arb_rd_data;
            end
            if (w_arb_en) begin
                r_cur_port     <= w_winner;
                r_last_port    <= w_winner;
                r_wen          <= w_sel_wen;
                o_arb_addr     <= w_sel_addr;
                o_arb_byte_sel <= w_sel_byte_sel;
                o_arb_wr_data  <= w_sel_wr_data;
                o_arb_func3    <= w_sel_func3;
            end
        end
    end

endmodule

// File: doc/riscv_dmem_arbiter.md
RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

Interface
REQ-001 Parameter ARB_RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 winning.
REQ-002 Data width SHALL be `XLEN (32) from riscv_configs.v; byte-select width SHALL be `XLEN/8.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 Per port k in {0,1}, requester inputs: i_arb_reqk (1), i_arb_addrk (XLEN), i_arb_wenk (1), i_arb_byte_selk (XLEN/8), i_arb_wr_datak (XLEN), i_arb_func3k (3).
REQ-006 Per port k, requester outputs: o_arb_gntk (1) grant pulse, o_arb_rvalidk (1) completion pulse, o_arb_rd_datak (XLEN) load result.
REQ-007 Memory-side outputs to the dmem interface: o_arb_addr (XLEN), o_arb_wen (1), o_arb_byte_sel (XLEN/8), o_arb_wr_data (XLEN), o_arb_func3 (3).
REQ-008 i_arb_rd_data  in  XLEN  aligned, extended read data from the dmem interface, valid in the RSP state.
REQ-009 o_arb_busy  out  1  high whenever state is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, ACC and RSP.
- IDLE->ACC when any req is high.
- ACC->RSP unconditionally.
- RSP->ACC when any req is high, else RSP->IDLE.
REQ-011 Arbitration SHALL run only in IDLE and RSP.
- The winner's addr, wen, byte_sel, wr_data and func3 SHALL be latched at that edge.
- The winner's index SHALL be latched into cur_port.
REQ-012 Round-robin (ARB_RR=1):
- Only one req high: that port wins.
- Both high: the port not equal to last_port wins.
- last_port SHALL update to the winner at each arbitration.
REQ-013 Fixed priority (ARB_RR=0): port 0 SHALL win whenever i_arb_req0 is high.
REQ-014 o_arb_gntk SHALL be high for exactly the one ACC cycle serving port k; the requester holds req and fields stable until it sees gnt.
REQ-015 o_arb_wen SHALL equal the latched wen during ACC and SHALL be 0 in IDLE and RSP.
REQ-016 o_arb_addr, o_arb_byte_sel, o_arb_wr_data and o_arb_func3 SHALL present the latched values in ACC and hold them through RSP, so the interface aligns read data with a stable addr[1:0] and func3.
REQ-017 At the RSP exit edge:
- o_arb_rvalid[cur_port] SHALL go high for exactly one cycle.
- For loads, o_arb_rd_data[cur_port] SHALL load i_arb_rd_data.
- For stores, rd_data SHALL be unchanged.
REQ-018 o_arb_rd_datak SHALL hold its value until the next load completes on port k.
REQ-019 Latency and throughput:
- Request sampled at edge N gives gnt in cycle N+1 and rvalid in cycle N+3.
- Back-to-back throughput SHALL be one access per 2 cycles.
REQ-020 At most one gnt and at most one rvalid SHALL be high in any cycle; gnt for the next access may coincide with rvalid of the previous one on either port.
REQ-021 A req deasserted before grant SHALL be ignored; no partial access occurs.

Reset
REQ-022 While i_rst is high at a rising edge:
- State SHALL go to IDLE and last_port to 1.
- All outputs, latched fields and rd_data registers SHALL go to 0.
REQ-023 Reset during ACC or RSP SHALL abort the access with no rvalid issued; a write already committed in ACC is not undone.
REQ-024 The first cycle after reset release SHALL be IDLE, with arbitration enabled on that edge.

Verification
REQ-025 Single load: port0 req, addr 0x104, func3 LW, mem data 0xDEADBEEF -> gnt0 at N+1; wen=0; rvalid0 at N+3 with rd_data0=0xDEADBEEF.
REQ-026 Single store: port1 req, addr 0x200, wen=1, byte_sel 4'hF, wr_data 0x12345678 -> gnt1 at N+1 with o_arb_wen=1 for exactly 1 cycle; rvalid1 at N+3; rd_data1 unchanged.
REQ-027 Contention, round-robin: both ports request continuously from reset -> grants alternate 0,1,0,1 at cycles N+1, N+3, N+5, N+7; never two gnts in one cycle.
REQ-028 Contention, ARB_RR=0: both ports request for 3 accesses -> only port 0 granted; port 1 granted only after req0 drops.
REQ-029 Reset mid-access: assert i_rst in the RSP cycle of a port0 load -> no rvalid0; all outputs 0 next cycle; busy=0.
REQ-030 Alignment hold: port0 LB at addr 0x103 -> o_arb_addr=0x103 and o_arb_func3=LB stable through ACC and RSP; rd_data0 equals the sign-extended byte 3 supplied on i_arb_rd_data.
